fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the 32-bit instruction memory.
- Owns the PC register and drives the memory address.
- Absorbs the memory's one-cycle registered read latency.
- Presents an IF/ID pipeline register (instruction, PC, valid) to decode, with stall back-pressure and branch/jump redirect flush.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 39 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch constants, the fetch packet type and the PC alignment helper
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP_DEFAULT  = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_pkt_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding register for a fetched word caught during a stall
module fetch_skid_buffer
    import mips_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_capture,
    input  logic               i_drain,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [31:0]        i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [31:0]        o_pc
);

    logic       r_valid;
    fetch_pkt_t r_pkt;

    // Flush outranks capture so a redirect during a stall discards the held word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pkt   <= '{instr: NOP_INSTR, pc: 32'h0};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_pkt   <= '{instr: i_instr, pc: i_pc};
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_pkt.instr;
    assign o_pc    = r_pkt.pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, registered-memory fetch and IF/ID register; FETCH_MISALIGN_TRAP_EN adds fetch_fault
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_STEP  = PC_STEP_DEFAULT
)
(
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_i,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               fetch_fault
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0]        r_pc_f;
    logic               r_req_v;
    logic [31:0]        r_req_pc;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_id_instr;
    logic [31:0]        r_id_pc;

    logic               w_skid_v;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [31:0]        w_skid_pc;
    logic               w_issue;
    logic               w_capture;
    logic               w_fault;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault     = r_fault;
    assign fetch_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    // A draining skid blocks issue, which yields the single bubble after a stall release.
    assign w_issue   = !w_fault && !w_skid_v && (!stall_i || !r_req_v);
    assign w_capture = stall_i && r_req_v && !w_skid_v;

    fetch_skid_buffer u_skid (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_capture (w_capture),
        .i_drain   (!stall_i),
        .i_flush   (redirect_valid),
        .i_instr   (imem_rdata),
        .i_pc      (r_req_pc),
        .o_valid   (w_skid_v),
        .o_instr   (w_skid_instr),
        .o_pc      (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f     <= RESET_PC;
            r_req_v    <= 1'b0;
            r_req_pc   <= 32'h0;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'h0;
        end else if (redirect_valid) begin
            if (!w_fault) begin
                r_pc_f <= align_pc(redirect_target);
            end
            r_req_v    <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else begin
            if (w_issue) begin
                r_req_v  <= 1'b1;
                r_req_pc <= r_pc_f;
                r_pc_f   <= r_pc_f + STEP;
            end else begin
                r_req_v  <= 1'b0;
            end
            if (!stall_i) begin
                if (w_skid_v) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= w_skid_instr;
                    r_id_pc    <= w_skid_pc;
                end else if (r_req_v) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= imem_rdata;
                    r_id_pc    <= r_req_pc;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_instr <= NOP_INSTR;
                end
            end
        end
    end

    assign imem_addr   = r_pc_f;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage, with FETCH_MISALIGN_TRAP_EN variant
module tb_fetch_stage;
    import mips_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_id_valid;
    logic [31:0] w_id_instr, w_id_pc, w_id_pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fetch_fault, w_fetch_fault;
`endif

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall_i         (stall_i),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (w_imem_addr),
        .imem_rdata      (w_imem_rdata),
        .stall_i         (w_zero),
        .redirect_valid  (w_zero),
        .redirect_target (w_zero32),
        .id_valid        (w_id_valid),
        .id_instr        (w_id_instr),
        .id_pc           (w_id_pc),
        .id_pc_plus4     (w_id_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (w_fetch_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Registered instruction memory: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        imem_rdata   <= mem_word(imem_addr);
        w_imem_rdata <= mem_word(w_imem_addr);
    end

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic faulted  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                        input logic ev, input logic [31:0] epc);
        exp_t e;
        stall_i         = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        e.v     = ev && !faulted;
        e.pc    = epc;
        e.instr = e.v ? mem_word(epc) : NOP_INSTR;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("id_valid", {31'h0, id_valid}, {31'h0, e.v});
        chk("id_instr", id_instr, e.instr);
        if (e.v) begin
            chk("id_pc", id_pc, e.pc);
            chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
    endtask

    initial begin
        reset = 1'b1;
        stall_i = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;

        step(0, 0, 32'h0, 0, 32'h0);
        chk("reset_id_pc", id_pc, 32'h0);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0, 32'h0);
        reset = 1'b0;

        step(0, 0, 32'h0, 0, 32'h0);
        chk("run_addr_4", imem_addr, 32'h4);
        step(0, 0, 32'h0, 1, 32'h0);
        chk("run_addr_8", imem_addr, 32'h8);
        step(0, 0, 32'h0, 1, 32'h4);
        step(0, 0, 32'h0, 1, 32'h8);
        chk("run_addr_16", imem_addr, 32'h10);

        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 32'h8);
        chk("stall_addr_hold", imem_addr, 32'h10);
        step(0, 0, 32'h0, 1, 32'hC);
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h10);
        step(0, 0, 32'h0, 1, 32'h14);

        step(0, 1, 32'h40, 0, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h40);
        step(0, 0, 32'h0, 1, 32'h44);

        step(1, 0, 32'h0, 1, 32'h44);
        step(1, 0, 32'h0, 1, 32'h44);
        step(1, 1, 32'h80, 0, 32'h0);
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h80);
        step(0, 0, 32'h0, 1, 32'h84);

        step(0, 1, 32'h46, 0, 32'h0);
        chk("misalign_addr", imem_addr, 32'h44);
        if (TRAP) faulted = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_set", {31'h0, fetch_fault}, 32'h1);
`endif
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h44);
        step(0, 0, 32'h0, 1, 32'h48);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_addr_hold", imem_addr, 32'h44);
`endif

        step(0, 1, 32'h100, 0, 32'h0);
        step(1, 0, 32'h0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h100);
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h104);
        step(1, 0, 32'h0, 1, 32'h104);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_addr_final", imem_addr, 32'h44);
`endif

        reset = 1'b1;
        step(1, 0, 32'h0, 0, 32'h0);
        faulted = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_cleared", {31'h0, fetch_fault}, 32'h0);
`endif
        reset = 1'b0;
        step(0, 0, 32'h0, 0, 32'h0);
        chk("rst_run_addr", imem_addr, 32'h4);
        chk("wrap_addr_0", w_imem_addr, 32'h0);
        chk("wrap_valid_0", {31'h0, w_id_valid}, 32'h0);
        step(0, 0, 32'h0, 1, 32'h0);
        chk("wrap_valid_1", {31'h0, w_id_valid}, 32'h1);
        chk("wrap_pc_top", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_instr_top", w_id_instr, mem_word(32'hFFFF_FFFC));
        chk("wrap_plus4", w_id_pc_plus4, 32'h0);
        step(0, 0, 32'h0, 1, 32'h4);
        chk("wrap_pc_zero", w_id_pc, 32'h0);
        chk("wrap_instr_zero", w_id_instr, mem_word(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
